n_bit_adder: RTL and testbench
==============================

# n_bit_adder

Parameterised WIDTH-bit binary adder with carry-in and carry-out, built as a ripple-carry chain of full-adder cells, with registered outputs. It is the basic arithmetic primitive for datapath blocks that need an unsigned add with carry propagation. It accepts one operation per clock and supports back-to-back operations.

## Interface
- WIDTH, default 4: operand and sum width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  reset, synchronous and active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered low WIDTH bits of a + b + cin.
- cout  output  1  registered carry out of bit WIDTH-1, i.e. bit WIDTH of a + b + cin.

## Operation
- Full-adder cell per bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = cin.
  - Cells are instantiated by a generate loop over WIDTH.
- Combinational result {c[WIDTH], s} equals a + b + cin computed in WIDTH+1 bits exactly.
- No inputs are wrapped or truncated except through the result format: the maximum result is (2^WIDTH−1)·2+1, which fits in WIDTH+1 bits, so no overflow beyond cout exists.
- Unsigned semantics only. No signed-overflow flag is produced.
- No handshake:
  - Every clock edge with rst_n high samples a new result.
  - Inputs must be stable for setup/hold around the rising edge.
- X or Z on inputs propagates. There is no special handling.

## Timing
- Reset:
  - On a rising edge with rst_n = 0, sum ← 0 and cout ← 0.
  - Any internal pipeline register is also cleared to 0.
- Reset takes priority over loading a result.
- Reset asserted mid-stream discards any in-flight result. The first valid output after rst_n rises follows the normal latency.
- Latency, without the configuration macro: 1 cycle.
  - Inputs present before edge N appear on sum/cout after edge N.
- Throughput: 1 operation per cycle in all configurations.
- Critical path is the WIDTH-cell ripple chain. No carry-lookahead is required.

## Configuration
- N_BIT_ADDER_INPUT_REG_EN:
  - When defined, a, b and cin are first captured in an input register stage (reset to 0 synchronously by rst_n). The adder operates on the registered values.
  - Total latency is then 2 cycles: inputs before edge N appear on outputs after edge N+1.
  - When undefined, there is no input register and latency is 1 cycle.
- Arithmetic results are identical in both builds; only latency differs.

## Test plan
All scenarios use WIDTH = 4. Check outputs after the configured latency and repeat each scenario with the macro defined and undefined.
- Reset: hold rst_n = 0 for 2 edges with a = 1111, b = 1111, cin = 1 -> sum = 0000, cout = 0. Release rst_n -> sum = 1110 + 1 = 1111, cout = 1 after latency.
- a = 0000, b = 0000, cin = 0 -> sum = 0000, cout = 0. Then a = 0001, b = 0001, cin = 0 -> sum = 0010, cout = 0.
- Wrap-around: a = 1111, b = 0001, cin = 0 -> sum = 0000, cout = 1. Also a = 1010, b = 0101, cin = 0 -> sum = 1111, cout = 0 (full propagate, no carry).
- Both max: a = 1111, b = 1111, cin = 0 -> sum = 1110, cout = 1. With cin = 1 -> sum = 1111, cout = 1.
- Carry-in: a = 0011, b = 0101, cin = 1 -> sum = 1001, cout = 0. Apply back-to-back with the previous vectors on consecutive cycles -> each result appears exactly one cycle apart.
- Exhaustive sweep of all 512 (a, b, cin) combinations, each checked against a reference a + b + cin. Assert rst_n once mid-sweep -> outputs are 0 on the following cycle and no stale result leaks out.

Source files
------------

// File: rtl/n_bit_adder_if.sv
// -----------------------------------------------------------------------------
// n_bit_adder_if
// Groups the operand and result signals of n_bit_adder.
//   WIDTH : operand / sum width in bits (>= 1)
//   a     : operand A, unsigned            (master -> slave)
//   b     : operand B, unsigned            (master -> slave)
//   cin   : carry into bit 0               (master -> slave)
//   sum   : registered low WIDTH bits      (slave -> master)
//   cout  : registered carry out of MSB    (slave -> master)
// Modports: master drives operands (testbench / upstream datapath),
//           slave is the adder itself.
// -----------------------------------------------------------------------------
interface n_bit_adder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout
    );
endinterface

// File: rtl/n_bit_adder.sv
// -----------------------------------------------------------------------------
// n_bit_adder
// WIDTH-bit unsigned ripple-carry adder with carry-in / carry-out and
// registered outputs. One operation accepted per clock, back-to-back.
//
// Ports:
//   clk   : rising-edge clock for all registers
//   rst_n : synchronous, active-low reset (clears every register to 0)
//   bus   : n_bit_adder_if.slave -- a, b, cin in; sum, cout out
//
// Configuration macro:
//   N_BIT_ADDER_INPUT_REG_EN
//     undefined : operands feed the ripple chain directly, latency 1 cycle.
//     defined   : a, b, cin are captured in an input register first,
//                 latency 2 cycles. Arithmetic is identical either way.
// -----------------------------------------------------------------------------
module n_bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    n_bit_adder_if.slave  bus
);

    // Operands as seen by the ripple chain (direct or registered).
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             op_cin_s;

    // Ripple chain: carry_s[i] is the carry into cell i.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    // Output registers.
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

`ifdef N_BIT_ADDER_INPUT_REG_EN
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;

    // Input capture stage; cleared with the rest of the pipe so a reset
    // mid-stream cannot leak a stale operand into the next result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            cin_r <= 1'b0;
        end else begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            cin_r <= bus.cin;
        end
    end

    assign op_a_s   = a_r;
    assign op_b_s   = b_r;
    assign op_cin_s = cin_r;
`else
    assign op_a_s   = bus.a;
    assign op_b_s   = bus.b;
    assign op_cin_s = bus.cin;
`endif

    assign carry_s[0] = op_cin_s;

    // One full-adder cell per bit; carry ripples LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_s[i]       = op_a_s[i] ^ op_b_s[i] ^ carry_s[i];
        assign carry_s[i+1]   = (op_a_s[i] & op_b_s[i])
                              | (carry_s[i] & (op_a_s[i] ^ op_b_s[i]));
    end

    // Result register; reset wins over loading a new result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= carry_s[WIDTH];
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_n_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_n_bit_adder
// Self-checking bench for n_bit_adder (WIDTH = 4). Each driven vector pushes
// its expected {cout, sum} into a scoreboard queue; once the queue holds the
// configured latency worth of entries, the oldest is popped and compared.
// Build with +define+N_BIT_ADDER_INPUT_REG_EN for the 2-cycle variant.
// -----------------------------------------------------------------------------
module tb_n_bit_adder;

    localparam int WIDTH = 4;
`ifdef N_BIT_ADDER_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;

    n_bit_adder_if #(.WIDTH(WIDTH)) bus ();

    n_bit_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH:0] exp_q[$];
    string          tag_q[$];

    int checks;
    int errors;

    // Drive one vector for one clock, update the scoreboard, and compare the
    // oldest entry once it has travelled through the full latency.
    task automatic step(input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb,
                        input logic             tc,
                        input logic             rn,
                        input string            tag);
        logic [WIDTH:0] exp_v;
        logic [WIDTH:0] obs_v;
        string          exp_tag;
        rst_n   = rn;
        bus.a   = ta;
        bus.b   = tb;
        bus.cin = tc;
        if (!rn) begin
            // Reset clears every in-flight result as well.
            foreach (exp_q[i]) exp_q[i] = '0;
            exp_q.push_back({(WIDTH+1){1'b0}});
        end else begin
            exp_q.push_back({1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc});
        end
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            exp_v   = exp_q.pop_front();
            exp_tag = tag_q.pop_front();
            obs_v   = {bus.cout, bus.sum};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s: observed cout/sum=%b/%b expected %b/%b",
                       exp_tag, obs_v[WIDTH], obs_v[WIDTH-1:0],
                       exp_v[WIDTH], exp_v[WIDTH-1:0]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;

        // Reset held for two edges with all-ones operands.
        step(4'b1111, 4'b1111, 1'b1, 1'b0, "reset0");
        step(4'b1111, 4'b1111, 1'b1, 1'b0, "reset1");
        step(4'b1111, 4'b1111, 1'b1, 1'b1, "release_max_cin");

        // Basic patterns, driven back-to-back.
        step(4'b0000, 4'b0000, 1'b0, 1'b1, "zero");
        step(4'b0001, 4'b0001, 1'b0, 1'b1, "one_plus_one");
        step(4'b1111, 4'b0001, 1'b0, 1'b1, "wrap");
        step(4'b1010, 4'b0101, 1'b0, 1'b1, "propagate");
        step(4'b1111, 4'b1111, 1'b0, 1'b1, "both_max");
        step(4'b1111, 4'b1111, 1'b1, 1'b1, "both_max_cin");
        step(4'b0011, 4'b0101, 1'b1, 1'b1, "carry_in");
        step(4'b0000, 4'b0000, 1'b1, 1'b1, "cin_only");

        // Exhaustive sweep with one reset pulse in the middle.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            if (i == 256) begin
                step(4'b1111, 4'b1111, 1'b1, 1'b0, "sweep_reset");
            end
            step(v[8:5], v[4:1], v[0], 1'b1, "sweep");
        end

        // Flush the pipeline so the final sweep vectors are compared.
        for (int i = 0; i < LAT; i++) begin
            step(4'b0000, 4'b0000, 1'b0, 1'b1, "flush");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
